// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiply sequencer: accepts one MULT/MULTU and returns HI/LO WIDTH+2 cycles after the handshake.
// No output backpressure; req_ready is low while busy or flushing, and the requester holds req_valid until accepted.
module booth_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo
);

  localparam int RW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth shift register: accumulator, multiplier and the appended q_1 bit.
  typedef struct packed {
    logic [RW-1:0] a;
    logic [RW-1:0] q;
    logic          q_1;
  } booth_t;

  state_t        state;
  state_t        state_nxt;
  booth_t        acc;
  booth_t        acc_step;
  logic [RW-1:0] m_reg;
  logic [RW-1:0] sum;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_step;

  // One extra bit keeps -M representable for every operand, signed or not.
  function automatic logic [RW-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  assign accept    = req_valid && req_ready;
  assign last_step = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !flush;
        if (req_valid && !flush) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        resp_valid = !flush && !reset;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One Booth step: conditional add/sub of M, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    case ({acc.q[0], acc.q_1})
      2'b01:   sum = acc.a + m_reg;
      2'b10:   sum = acc.a - m_reg;
      default: sum = acc.a;
    endcase
    acc_step.a   = {sum[RW-1], sum[RW-1:1]};
    acc_step.q   = {sum[0], acc.q[RW-1:1]};
    acc_step.q_1 = acc.q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      m_reg   <= '0;
      count   <= '0;
      resp_hi <= '0;
      resp_lo <= '0;
    end else if (state == IDLE && accept) begin
      m_reg     <= ext(req_a, req_signed);
      acc.a     <= '0;
      acc.q     <= ext(req_b, req_signed);
      acc.q_1   <= 1'b0;
      count     <= CW'(RW);
    end else if (state == RUN && !flush) begin
      acc   <= acc_step;
      count <= count - CW'(1);
      // Product is the low 2*WIDTH bits of {A,Q} after the final step.
      if (last_step) begin
        resp_hi <= {acc_step.a[WIDTH-2:0], acc_step.q[WIDTH]};
        resp_lo <= acc_step.q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: table vectors, random vectors, and
// hand-written flush / back-to-back / reset sequences, all scored through a queue.
module tb_booth_mult_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_signed;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         flush;
  logic         busy;
  logic         resp_valid;
  logic [W-1:0] resp_hi;
  logic [W-1:0] resp_lo;

  always #5 clk = ~clk;

  booth_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_signed(req_signed),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_hi   (resp_hi),
    .resp_lo   (resp_lo)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    int          hs_cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        prev_vld = 1'b0;
  logic [63:0] last_prod = 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      check("resp_single_pulse", {63'h0, prev_vld}, 64'h0);
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'h1, 64'h0);
      end else begin
        e = sb.pop_front();
        check("resp_product", {resp_hi, resp_lo}, e.prod);
        check("resp_latency", 64'(cyc - e.hs_cyc), 64'd34);
        last_prod = e.prod;
      end
    end
    prev_vld = resp_valid;
  end

  // Called in the cycle after an edge; returns in cycle t+1 where t is the handshake cycle.
  task automatic do_req(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p, input bit expect_resp, output int hs);
    int waited;
    waited     = 0;
    hs         = -1;
    req_signed = sgn;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    while (hs < 0 && waited < 100) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        hs = cyc;
        if (expect_resp) sb.push_back('{prod: p, hs_cyc: cyc});
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (hs < 0) check("req_accept_timeout", 64'h1, 64'h0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_timeout", 64'(sb.size()), 64'h0);
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sbv;
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  initial begin
    int hs;
    int hs1;
    int hs2;
    int hs3;
    int nb;
    int nv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[4] = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vecs[5] = '{1'b0, 32'h00000005, 32'h00000006, 64'h00000000_0000001E};
    vecs[6] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[7] = '{1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000};
    vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE};
    vecs[9] = '{1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst_resp_hi", {32'h0, resp_hi}, 64'h0);
    check("rst_resp_lo", {32'h0, resp_lo}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_req_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    #1;

    // Busy window around a single signed multiply.
    do_req(1'b1, 32'hFFFFFFFD, 32'h7, 64'hFFFFFFFF_FFFFFFEB, 1'b1, hs);
    req_valid = 1'b0;
    nb = 0;
    repeat (34) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    @(negedge clk);
    check("busy_cycles", 64'(nb), 64'd34);
    check("busy_after_done", {63'h0, busy}, 64'h0);
    check("ready_after_done", {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    #1;
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].prod, 1'b1, hs);
      req_valid = 1'b0;
      wait_drain();
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      do_req(rs, ra, rb, model(rs, ra, rb), 1'b1, hs);
      req_valid = 1'b0;
      wait_drain();
    end

    // Flush at t+10 aborts the multiply and leaves HI/LO untouched.
    do_req(1'b0, 32'h1234, 32'h5678, 64'h0, 1'b0, hs);
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_ready_low", {63'h0, req_ready}, 64'h0);
    check("flush_busy_run", {63'h0, busy}, 64'h1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready_after", {63'h0, req_ready}, 64'h1);
    check("flush_busy_after", {63'h0, busy}, 64'h0);
    check("flush_hilo_hold", {resp_hi, resp_lo}, last_prod);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid === 1'b1) nv++;
    end
    check("flush_no_resp", 64'(nv), 64'h0);
    check("flush_hilo_hold_late", {resp_hi, resp_lo}, last_prod);
    @(posedge clk);
    #1;
    do_req(1'b0, 32'd5, 32'd6, 64'h1E, 1'b1, hs);
    req_valid = 1'b0;
    wait_drain();

    // Flush while idle blocks a simultaneous request.
    req_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    check("idle_flush_ready", {63'h0, req_ready}, 64'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    check("idle_flush_not_accepted", {63'h0, busy}, 64'h0);
    @(posedge clk);
    #1;

    // req_valid held high across three back-to-back requests.
    do_req(1'b0, 32'd3, 32'd4, 64'hC, 1'b1, hs1);
    do_req(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 1'b1, hs2);
    do_req(1'b0, 32'h100, 32'h100, 64'h10000, 1'b1, hs3);
    req_valid = 1'b0;
    check("b2b_spacing_1", 64'(hs2 - hs1), 64'd35);
    check("b2b_spacing_2", 64'(hs3 - hs2), 64'd35);
    wait_drain();

    // Reset mid-RUN: nothing completes and every output returns to zero.
    do_req(1'b1, 32'd7, 32'd7, 64'h0, 1'b0, hs);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("midrst_resp_hi", {32'h0, resp_hi}, 64'h0);
    check("midrst_resp_lo", {32'h0, resp_lo}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_ready", {63'h0, req_ready}, 64'h1);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid === 1'b1) nv++;
    end
    check("midrst_no_resp", 64'(nv), 64'h0);

    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
